// File: rtl/led_rotator_param.sv
// Parametrised one-hot LED chaser: prescaled step tick, run-enable, direction.
// Optional ping-pong mode when LED_BOUNCE_EN is defined; default build is rotate only.
module led_rotator_param #(
    parameter  int N_LEDS = 4,
    parameter  int DIV    = 25000,
    localparam int POS_W  = (N_LEDS > 1) ? $clog2(N_LEDS) : 1,
    localparam int CNT_W  = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              dir,
    input  logic              mode,
    output logic [N_LEDS-1:0] led,
    output logic [POS_W-1:0]  pos,
    output logic              step
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DIV - 1);
    localparam logic [POS_W-1:0] LAST   = POS_W'(N_LEDS - 1);

    logic [CNT_W-1:0]  r_cnt;
    logic [POS_W-1:0]  r_pos;
    logic [N_LEDS-1:0] r_led;
    logic              r_step;

    logic              w_tick;
    logic [POS_W-1:0]  w_pos_up;
    logic [POS_W-1:0]  w_pos_dn;
    logic [POS_W-1:0]  w_pos_nxt;
    logic [N_LEDS-1:0] w_led_nxt;

    assign w_tick = en && (r_cnt == '0);

    // Wrapping neighbours; with N_LEDS=1 both collapse to position 0
    assign w_pos_up = (r_pos == LAST) ? '0 : r_pos + POS_W'(1);
    assign w_pos_dn = (r_pos == '0) ? LAST : r_pos - POS_W'(1);

`ifdef LED_BOUNCE_EN
    logic r_bdir;
    logic r_bmode;
    logic w_bdir_eff;
    logic w_bdir_nxt;
    logic [POS_W-1:0] w_pos_bnc;

    // First tick after entering ping-pong takes its direction from dir
    assign w_bdir_eff = r_bmode ? r_bdir : dir;

    always_comb begin
        w_pos_bnc  = r_pos;
        w_bdir_nxt = w_bdir_eff;
        if (N_LEDS == 1) begin
            w_pos_bnc  = '0;
        end else if (w_bdir_eff) begin
            if (r_pos == LAST) begin
                w_pos_bnc  = w_pos_dn;
                w_bdir_nxt = 1'b0;
            end else begin
                w_pos_bnc  = w_pos_up;
                w_bdir_nxt = 1'b1;
            end
        end else begin
            if (r_pos == '0) begin
                w_pos_bnc  = w_pos_up;
                w_bdir_nxt = 1'b1;
            end else begin
                w_pos_bnc  = w_pos_dn;
                w_bdir_nxt = 1'b0;
            end
        end
    end

    always_comb begin
        w_pos_nxt = dir ? w_pos_up : w_pos_dn;
        if (mode) begin
            w_pos_nxt = w_pos_bnc;
        end
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            r_bdir  <= 1'b0;
            r_bmode <= 1'b0;
        end else if (w_tick) begin
            r_bmode <= mode;
            if (mode) begin
                r_bdir <= w_bdir_nxt;
            end
        end
    end
`else
    logic w_unused_mode;

    assign w_unused_mode = mode;

    always_comb begin
        w_pos_nxt = dir ? w_pos_up : w_pos_dn;
    end
`endif

    assign w_led_nxt = N_LEDS'(1) << w_pos_nxt;

    always_ff @(negedge clk) begin
        if (reset) begin
            r_cnt  <= RELOAD;
            r_pos  <= LAST;
            r_led  <= N_LEDS'(1) << LAST;
            r_step <= 1'b0;
        end else begin
            r_step <= w_tick;
            if (en) begin
                r_cnt <= (r_cnt == '0) ? RELOAD : r_cnt - CNT_W'(1);
            end
            if (w_tick) begin
                r_pos <= w_pos_nxt;
                r_led <= w_led_nxt;
            end
        end
    end

    assign led  = r_led;
    assign pos  = r_pos;
    assign step = r_step;

endmodule

// File: tb/tb_led_rotator_param.sv
// Bench for led_rotator_param: directed scenarios plus randomized run
// against a count-based reference model (4 LEDs/DIV 4 and 5 LEDs/DIV 1).
module tb_led_rotator_param;

    logic       clk;
    logic       reset;
    logic       en;
    logic       dir;
    logic       mode;
    logic [3:0] led4;
    logic [1:0] pos4;
    logic       step4;
    logic [4:0] led5;
    logic [2:0] pos5;
    logic       step5;

    int checks = 0;
    int errors = 0;

    led_rotator_param #(.N_LEDS(4), .DIV(4)) u_dut4 (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .mode(mode),
        .led(led4), .pos(pos4), .step(step4)
    );

    led_rotator_param #(.N_LEDS(5), .DIV(1)) u_dut5 (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .mode(mode),
        .led(led5), .pos(pos5), .step(step5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state per instance: 0 = 4 LEDs/DIV 4, 1 = 5 LEDs/DIV 1
    int m_n[2]   = '{4, 5};
    int m_div[2] = '{4, 1};
    int m_pos[2];
    int m_cnt[2];
    bit m_step[2];
    bit m_bdir[2];
    bit m_blast[2];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input int k);
        int n;
        bit d;
        n = m_n[k];
        if (reset) begin
            m_pos[k]   = n - 1;
            m_cnt[k]   = 0;
            m_step[k]  = 0;
            m_bdir[k]  = 0;
            m_blast[k] = 0;
        end else if (!en) begin
            m_step[k] = 0;
        end else begin
            m_cnt[k]++;
            m_step[k] = (m_cnt[k] == m_div[k]);
            if (m_step[k]) begin
                m_cnt[k] = 0;
`ifdef LED_BOUNCE_EN
                if (mode) begin
                    d = m_blast[k] ? m_bdir[k] : dir;
                    if (n == 1) m_pos[k] = 0;
                    else if (d && m_pos[k] == n - 1) begin
                        m_pos[k] = n - 2; m_bdir[k] = 0;
                    end else if (d) begin
                        m_pos[k]++; m_bdir[k] = 1;
                    end else if (m_pos[k] == 0) begin
                        m_pos[k] = 1; m_bdir[k] = 1;
                    end else begin
                        m_pos[k]--; m_bdir[k] = 0;
                    end
                    m_blast[k] = 1;
                end else begin
                    m_pos[k] = dir ? (m_pos[k] + 1) % n
                                   : (m_pos[k] + n - 1) % n;
                    m_blast[k] = 0;
                end
`else
                d = dir;
                m_pos[k] = d ? (m_pos[k] + 1) % n : (m_pos[k] + n - 1) % n;
`endif
            end
        end
    endtask

    // One active (falling) edge, then compare both instances to the model
    task automatic cyc();
        @(negedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        chk("led4", 32'(led4), 32'(1) << m_pos[0]);
        chk("pos4", 32'(pos4), 32'(m_pos[0]));
        chk("step4", 32'(step4), 32'(m_step[0]));
        chk("onehot4", 32'($onehot(led4)), 32'd1);
        chk("led5", 32'(led5), 32'(1) << m_pos[1]);
        chk("pos5", 32'(pos5), 32'(m_pos[1]));
        chk("step5", 32'(step5), 32'(m_step[1]));
        chk("onehot5", 32'($onehot(led5)), 32'd1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    logic [3:0] seq1[4];
    logic [3:0] seq6[7];
    int         seq5[6];

    initial begin
        seq1 = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};
        seq5 = '{4, 0, 1, 2, 3, 4};
`ifdef LED_BOUNCE_EN
        seq6 = '{4'b0100, 4'b0010, 4'b0001, 4'b0010,
                 4'b0100, 4'b1000, 4'b0100};
`else
        seq6 = '{4'b0100, 4'b0010, 4'b0001, 4'b1000,
                 4'b0100, 4'b0010, 4'b0001};
`endif
        #2;
        reset = 1; en = 1; dir = 0; mode = 0;
        run(2);
        chk("rst_led", 32'(led4), 32'b1000);
        chk("rst_pos", 32'(pos4), 32'd3);
        chk("rst_step", 32'(step4), 32'd0);
        reset = 0;

        // Wrap rotate toward LSB, step every 4th cycle
        for (int t = 0; t < 4; t++) begin
            run(3);
            chk("s1_nostep", 32'(step4), 32'd0);
            run(1);
            chk("s1_step", 32'(step4), 32'd1);
            chk("s1_led", 32'(led4), 32'(seq1[t]));
        end

        // Direction change mid-period at led 0010
        run(8);
        chk("s2_at", 32'(led4), 32'b0010);
        run(2);
        dir = 1;
        run(1);
        chk("s2_nostep", 32'(step4), 32'd0);
        run(1);
        chk("s2_step", 32'(step4), 32'd1);
        chk("s2_led", 32'(led4), 32'b0100);
        run(3);
        chk("s2_gap", 32'(step4), 32'd0);
        run(1);
        chk("s2_step2", 32'(step4), 32'd1);
        chk("s2_led2", 32'(led4), 32'b1000);

        // Freeze with en=0, resume continues the count
        run(2);
        en = 0;
        run(10);
        chk("s3_led", 32'(led4), 32'b1000);
        chk("s3_step", 32'(step4), 32'd0);
        en = 1;
        run(1);
        chk("s3_nostep", 32'(step4), 32'd0);
        run(1);
        chk("s3_step", 32'(step4), 32'd1);
        chk("s3_led2", 32'(led4), 32'b0001);

        // Reset pulse mid-period
        run(2);
        reset = 1;
        run(1);
        chk("s4_led", 32'(led4), 32'b1000);
        chk("s4_pos", 32'(pos4), 32'd3);
        chk("s4_step", 32'(step4), 32'd0);
        reset = 0;
        run(3);
        chk("s4_nostep", 32'(step4), 32'd0);
        run(1);
        chk("s4_step2", 32'(step4), 32'd1);
        chk("s4_led2", 32'(led4), 32'b0001);

        // Five LEDs, DIV=1, toward MSB
        reset = 1; dir = 1;
        run(1);
        reset = 0;
        chk("s5_pos0", 32'(pos5), 32'(seq5[0]));
        for (int t = 1; t < 6; t++) begin
            run(1);
            chk("s5_pos", 32'(pos5), 32'(seq5[t]));
            chk("s5_step", 32'(step5), 32'd1);
        end

        // Ping-pong request (plain wrap when the feature is absent)
        reset = 1; dir = 0; mode = 1;
        run(1);
        reset = 0;
        for (int t = 0; t < 7; t++) begin
            run(4);
            chk("s6_led", 32'(led4), 32'(seq6[t]));
        end

        // Randomized run against the model
        for (int i = 0; i < 800; i++) begin
            reset = ($urandom_range(0, 59) == 0);
            en    = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) dir = 1'($urandom);
            if ($urandom_range(0, 29) == 0) mode = ~mode;
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
